pc_fetch_ctrl: RTL

- Instruction-fetch sequencer for the single-issue RV64 core; owns the architectural fetch PC register.
- Issues one fetch request at a time to instruction memory over a valid/ready + response handshake.
- Hands the returned instruction to decode, and applies redirects (new PC from the branch/jump PC-select logic in EX).
- Stale responses are discarded after a redirect; the PC is held while decode stalls.

---
 rtl/pc_fetch_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one request at a time,
// presents returned instructions to decode and applies EX redirects.
module pc_fetch_ctrl #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000_0000_8000_0000)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            if_req_valid,
    output logic [XLEN-1:0] if_req_addr,
    input  logic            if_req_ready,
    input  logic            if_rsp_valid,
    input  logic [31:0]     if_rsp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_pc,
    output logic [31:0]     inst,
    output logic            misalign
);

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_REQ,
        ST_WAIT,
        ST_DROP,
        ST_OUT
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic              r_reqValid;
    logic              r_instValid;
    logic [XLEN-1:0]   r_instPc;
    logic [31:0]       r_inst;
    logic              r_misalign;

    logic [XLEN-1:0]   w_redirTarget;
    logic              w_redirMisaligned;
    logic [XLEN-1:0]   w_pcPlus4;

    // Redirect targets are forced to word alignment; the low bits only raise misalign.
    assign w_redirTarget     = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_redirMisaligned = |redirect_pc[1:0];
    assign w_pcPlus4         = r_pc + XLEN'(4);

    assign if_req_valid = r_reqValid;
    assign if_req_addr  = r_pc;
    assign inst_valid   = r_instValid;
    assign inst_pc      = r_instPc;
    assign inst         = r_inst;
    assign misalign     = r_misalign;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_PC;
            r_reqValid  <= 1'b0;
            r_instValid <= 1'b0;
            r_instPc    <= '0;
            r_inst      <= '0;
            r_misalign  <= 1'b0;
        end else begin
            r_misalign <= redirect_valid && w_redirMisaligned;
            case (r_state)
                ST_BOOT: begin
                    if (redirect_valid) begin
                        r_pc <= w_redirTarget;
                    end
                    r_state    <= ST_REQ;
                    r_reqValid <= 1'b1;
                end
                ST_REQ: begin
                    // Retargeting an unaccepted request is legal; an accepted one must be drained.
                    if (redirect_valid) begin
                        r_pc <= w_redirTarget;
                    end
                    if (if_req_ready) begin
                        r_state    <= redirect_valid ? ST_DROP : ST_WAIT;
                        r_reqValid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (redirect_valid) begin
                        r_pc <= w_redirTarget;
                        if (if_rsp_valid) begin
                            r_state    <= ST_REQ;
                            r_reqValid <= 1'b1;
                        end else begin
                            r_state <= ST_DROP;
                        end
                    end else if (if_rsp_valid) begin
                        r_inst      <= if_rsp_data;
                        r_instPc    <= r_pc;
                        r_instValid <= 1'b1;
                        r_state     <= ST_OUT;
                    end
                end
                ST_DROP: begin
                    if (redirect_valid) begin
                        r_pc <= w_redirTarget;
                    end
                    if (if_rsp_valid) begin
                        r_state    <= ST_REQ;
                        r_reqValid <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (redirect_valid) begin
                        r_pc        <= w_redirTarget;
                        r_instValid <= 1'b0;
                        r_state     <= ST_REQ;
                        r_reqValid  <= 1'b1;
                    end else if (!stall) begin
                        r_pc        <= w_pcPlus4;
                        r_instValid <= 1'b0;
                        r_state     <= ST_REQ;
                        r_reqValid  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_BOOT;
                    r_reqValid  <= 1'b0;
                    r_instValid <= 1'b0;
                end
            endcase
        end
    end

endmodule
